regfile_mp_sb: RTL

REGFILE_MP_SB -- requirements
Module: regfile_mp_sb

---
 rtl/regfile_mp_sb.sv | 92 +++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: 2-write/3-read lane-masked register file with same-cycle bypass and a busy scoreboard.
module regfile_mp_sb #(
   parameter int DEPTH      = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wrEn0,
   input  logic                  wrEn1,
   input  logic [ADDR_WIDTH-1:0] wrAddr0,
   input  logic [ADDR_WIDTH-1:0] wrAddr1,
   input  logic [0:DATA_WIDTH-1] dataIn0,
   input  logic [0:DATA_WIDTH-1] dataIn1,
   input  logic [0:2]            ppp0,
   input  logic [0:2]            ppp1,
   input  logic [ADDR_WIDTH-1:0] rdAddr0,
   input  logic [ADDR_WIDTH-1:0] rdAddr1,
   input  logic [ADDR_WIDTH-1:0] rdAddr2,
   output logic [0:DATA_WIDTH-1] dataOut0,
   output logic [0:DATA_WIDTH-1] dataOut1,
   output logic [0:DATA_WIDTH-1] dataOut2,
   input  logic                  setBusy,
   input  logic [ADDR_WIDTH-1:0] setAddr,
   output logic                  rdBusy0,
   output logic                  rdBusy1,
   output logic                  rdBusy2
);
   localparam int W = DATA_WIDTH;
   logic [0:W-1]     regs [DEPTH];
   logic [0:W-1]     nxt  [DEPTH];
   logic [0:W-1]     k0   [DEPTH];
   logic [0:W-1]     k1   [DEPTH];
   logic [0:W-1]     m0, m1;
   logic [DEPTH-1:0] busy, clr, set;
   // Byte 0 is the most significant byte; halves are byte aligned since W is a multiple of 16.
   function automatic logic [0:W-1] lanes(input logic [2:0] p);
      logic [0:W-1] m;
      m = '0;
      for (int b = 0; b < W/8; b++)
         if (p == 3'd0 || (p == 3'd1 && b < W/16) || (p == 3'd2 && b >= W/16) ||
             (p == 3'd3 && b % 2 == 0) || (p == 3'd4 && b % 2 == 1))
            m[8*b +: 8] = '1;
      return m;
   endfunction
   assign m0 = wrEn0 ? lanes(ppp0) : '0;
   assign m1 = wrEn1 ? lanes(ppp1) : '0;
   // nxt doubles as the bypassed read value and the next register state; port 1 wins overlaps.
   always_comb begin
      clr = '0;
      set = '0;
      for (int i = 0; i < DEPTH; i++) begin
         k0[i]  = (i != 0 && wrAddr0 == ADDR_WIDTH'(i)) ? m0 : '0;
         k1[i]  = (i != 0 && wrAddr1 == ADDR_WIDTH'(i)) ? m1 : '0;
         nxt[i] = (regs[i] & ~(k0[i] | k1[i])) | (dataIn0 & k0[i] & ~k1[i]) | (dataIn1 & k1[i]);
         clr[i] = i != 0 && ((wrEn0 && ppp0 <= 3'd4 && wrAddr0 == ADDR_WIDTH'(i)) ||
                             (wrEn1 && ppp1 <= 3'd4 && wrAddr1 == ADDR_WIDTH'(i)));
         set[i] = i != 0 && setBusy && setAddr == ADDR_WIDTH'(i);
      end
   end
   always_comb begin
      dataOut0 = '0;
      dataOut1 = '0;
      dataOut2 = '0;
      rdBusy0  = 1'b0;
      rdBusy1  = 1'b0;
      rdBusy2  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!reset && rdAddr0 == ADDR_WIDTH'(i)) begin
            dataOut0 = nxt[i];
            rdBusy0  = busy[i] & ~clr[i];
         end
         if (!reset && rdAddr1 == ADDR_WIDTH'(i)) begin
            dataOut1 = nxt[i];
            rdBusy1  = busy[i] & ~clr[i];
         end
         if (!reset && rdAddr2 == ADDR_WIDTH'(i)) begin
            dataOut2 = nxt[i];
            rdBusy2  = busy[i] & ~clr[i];
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= nxt[i];
         busy <= (busy & ~clr) | set;
      end
   end
endmodule
